// File: rtl/eic_ahb_regs.sv
// AHB-Lite register file for the external interrupt controller: channel enable mask,
// per-channel sense mode, forced flag set/clear strobes and pending/IRQ readback.
module eic_ahb_regs #(
    parameter int unsigned EIC_DIRECT_CHANNELS = 32,
    parameter int unsigned EIC_SENSE_CHANNELS  = 32,
    parameter int unsigned EIC_TOTAL_CHANNELS  = EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS
) (
    input  logic                            CLK,
    input  logic                            RESETn,
    input  logic                            HSEL,
    input  logic [31:0]                     HADDR,
    input  logic [1:0]                      HTRANS,
    input  logic                            HWRITE,
    input  logic [2:0]                      HSIZE,
    input  logic [31:0]                     HWDATA,
    input  logic                            HREADY,
    output logic [31:0]                     HRDATA,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    output logic [EIC_TOTAL_CHANNELS-1:0]   mask,
    output logic [2*EIC_SENSE_CHANNELS-1:0] senseMask,
    output logic [EIC_TOTAL_CHANNELS-1:0]   requestWR,
    output logic [EIC_TOTAL_CHANNELS-1:0]   requestIn,
    input  logic [EIC_TOTAL_CHANNELS-1:0]   request,
    input  logic [7:0]                      eicInterrupt
);

    localparam int unsigned TOT = EIC_TOTAL_CHANNELS;
    localparam int unsigned SW  = 2 * EIC_SENSE_CHANNELS;

    typedef enum logic [3:0] {
        REG_CTRL   = 4'h0,
        REG_MASK0  = 4'h1,
        REG_MASK1  = 4'h2,
        REG_FLAG0  = 4'h3,
        REG_FLAG1  = 4'h4,
        REG_FSET0  = 4'h5,
        REG_FSET1  = 4'h6,
        REG_FCLR0  = 4'h7,
        REG_FCLR1  = 4'h8,
        REG_SENSE0 = 4'h9,
        REG_SENSE1 = 4'hA,
        REG_IRQ    = 4'hB
    } reg_addr_e;

    logic           dp_valid;
    logic           dp_write;
    logic           dp_size_ok;
    logic [3:0]     dp_addr;
    logic           accept;
    logic           wr_en;

    logic           gen;
    logic [TOT-1:0] mask_reg;
    logic [SW-1:0]  sense_reg;

    logic           gen_nxt;
    logic [63:0]    mask_nxt;
    logic [63:0]    sense_nxt;
    logic [63:0]    strobe;
    logic           strobe_set;

    logic [63:0]    mask_ext;
    logic [63:0]    sense_ext;
    logic [63:0]    req_ext;

    logic           unused_bits;

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign wr_en     = dp_valid & dp_write & dp_size_ok;
    assign mask_ext  = 64'(mask_reg);
    assign sense_ext = 64'(sense_reg);
    assign req_ext   = 64'(request);

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign mask      = mask_reg & {TOT{gen}};
    assign senseMask = sense_reg;

    assign unused_bits = ^{HADDR[31:6], HADDR[1:0], HTRANS[0]};

    // Registers are widened to 64 bits for the word-wise update; bits above the
    // configured channel count are dropped when the result is stored.
    always_comb begin
        gen_nxt    = gen;
        mask_nxt   = mask_ext;
        sense_nxt  = sense_ext;
        strobe     = '0;
        strobe_set = 1'b0;
        if (wr_en) begin
            case (dp_addr)
                REG_CTRL:   gen_nxt = HWDATA[0];
                REG_MASK0:  mask_nxt[31:0] = HWDATA;
                REG_MASK1:  mask_nxt[63:32] = HWDATA;
                REG_FSET0:  begin strobe[31:0]  = HWDATA; strobe_set = 1'b1; end
                REG_FSET1:  begin strobe[63:32] = HWDATA; strobe_set = 1'b1; end
                REG_FCLR0:  strobe[31:0]  = HWDATA;
                REG_FCLR1:  strobe[63:32] = HWDATA;
                REG_SENSE0: sense_nxt[31:0] = HWDATA;
                REG_SENSE1: sense_nxt[63:32] = HWDATA;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_size_ok <= 1'b0;
            dp_addr    <= '0;
            gen        <= 1'b0;
            mask_reg   <= '0;
            sense_reg  <= '0;
            requestWR  <= '0;
            requestIn  <= '0;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                dp_write   <= HWRITE;
                dp_addr    <= HADDR[5:2];
                dp_size_ok <= (HSIZE == 3'b010);
            end
            gen       <= gen_nxt;
            mask_reg  <= mask_nxt[TOT-1:0];
            sense_reg <= sense_nxt[SW-1:0];
            requestWR <= strobe[TOT-1:0];
            requestIn <= strobe_set ? strobe[TOT-1:0] : '0;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                REG_CTRL:   HRDATA = {31'd0, gen};
                REG_MASK0:  HRDATA = mask_ext[31:0];
                REG_MASK1:  HRDATA = mask_ext[63:32];
                REG_FLAG0:  HRDATA = req_ext[31:0];
                REG_FLAG1:  HRDATA = req_ext[63:32];
                REG_SENSE0: HRDATA = sense_ext[31:0];
                REG_SENSE1: HRDATA = sense_ext[63:32];
                REG_IRQ:    HRDATA = {24'd0, eicInterrupt};
                default:    HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_eic_ahb_regs.sv
// Bench for eic_ahb_regs: two instances (full size and 8 sense / 40 total channels)
// compared every cycle against a register-level model, plus directed scenarios.
module tb_eic_ahb_regs;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rstn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [63:0] req;
    logic [7:0]  irq;

    logic [31:0] hrdata, hrdata8;
    logic        hreadyout, hresp, hreadyout8, hresp8;
    logic [63:0] mask_o, req_wr, req_in, sense_o;
    logic [39:0] mask8, req_wr8, req_in8;
    logic [15:0] sense8;

    eic_ahb_regs dut (
        .CLK(CLK), .RESETn(rstn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
        .mask(mask_o), .senseMask(sense_o), .requestWR(req_wr), .requestIn(req_in),
        .request(req), .eicInterrupt(irq)
    );

    eic_ahb_regs #(.EIC_DIRECT_CHANNELS(32), .EIC_SENSE_CHANNELS(8)) dut8 (
        .CLK(CLK), .RESETn(rstn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(hrdata8), .HREADYOUT(hreadyout8), .HRESP(hresp8),
        .mask(mask8), .senseMask(sense8), .requestWR(req_wr8), .requestIn(req_in8),
        .request(req[39:0]), .eicInterrupt(irq)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Register-level model, one entry per instance
    int unsigned tot_ch [2] = '{64, 40};
    int unsigned sen_ch [2] = '{32, 8};
    logic        m_gen   [2];
    logic [63:0] m_mask  [2];
    logic [63:0] m_sense [2];
    logic [63:0] e_wr    [2];
    logic [63:0] e_in    [2];
    logic        p_valid, p_write, p_size_ok;
    logic [3:0]  p_off;
    bit          m_init = 0;

    logic [31:0] s_hrdata, s_hrdata8;
    logic [63:0] s_mask, s_wr, s_in, s_sense;

    function automatic logic [63:0] lim(input int unsigned n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [3:0] off);
        logic [63:0] r;
        r = req & lim(tot_ch[d]);
        case (off)
            4'd0:    return {31'd0, m_gen[d]};
            4'd1:    return m_mask[d][31:0];
            4'd2:    return m_mask[d][63:32];
            4'd3:    return r[31:0];
            4'd4:    return r[63:32];
            4'd9:    return m_sense[d][31:0];
            4'd10:   return m_sense[d][63:32];
            4'd11:   return {24'd0, irq};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input int d, input logic [3:0] off, input logic [31:0] w);
        logic [63:0] t;
        logic [63:0] s;
        t = lim(tot_ch[d]);
        s = lim(2 * sen_ch[d]);
        case (off)
            4'd0:  m_gen[d] = w[0];
            4'd1:  m_mask[d] = {m_mask[d][63:32], w} & t;
            4'd2:  m_mask[d] = {w, m_mask[d][31:0]} & t;
            4'd5:  begin e_wr[d] = {32'd0, w} & t; e_in[d] = e_wr[d]; end
            4'd6:  begin e_wr[d] = {w, 32'd0} & t; e_in[d] = e_wr[d]; end
            4'd7:  begin e_wr[d] = {32'd0, w} & t; e_in[d] = '0; end
            4'd8:  begin e_wr[d] = {w, 32'd0} & t; e_in[d] = '0; end
            4'd9:  m_sense[d] = {m_sense[d][63:32], w} & s;
            4'd10: m_sense[d] = {w, m_sense[d][31:0]} & s;
            default: ;
        endcase
    endtask

    // One bus cycle: address phase (sel/trans/wr/addr/size) plus write data for the
    // data phase issued in the previous cycle. Checks the outputs mid-cycle.
    task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [5:0] boff, input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] a;
        logic [63:0] g_rd, g_mask, g_wr, g_in, g_sense, x_rd;
        a = $urandom();
        a[5:0] = {boff[5:2], 2'b00};
        hsel = sel; htrans = trans; hwrite = wr; haddr = a; hsize = size; hwdata = wdata;
        @(negedge CLK);
        s_hrdata = hrdata; s_hrdata8 = hrdata8;
        s_mask = mask_o; s_wr = req_wr; s_in = req_in; s_sense = sense_o;
        check("hreadyout", {63'd0, hreadyout & hreadyout8}, 64'd1);
        check("hresp", {63'd0, hresp | hresp8}, 64'd0);
        if (m_init) begin
            for (int d = 0; d < 2; d++) begin
                g_rd    = (d == 0) ? 64'(hrdata)  : 64'(hrdata8);
                g_mask  = (d == 0) ? mask_o       : 64'(mask8);
                g_wr    = (d == 0) ? req_wr       : 64'(req_wr8);
                g_in    = (d == 0) ? req_in       : 64'(req_in8);
                g_sense = (d == 0) ? sense_o      : 64'(sense8);
                x_rd    = (p_valid && !p_write) ? 64'(model_read(d, p_off)) : 64'd0;
                check((d == 0) ? "hrdata" : "hrdata8", g_rd, x_rd);
                check((d == 0) ? "mask" : "mask8", g_mask, m_gen[d] ? m_mask[d] : 64'd0);
                check((d == 0) ? "reqwr" : "reqwr8", g_wr, e_wr[d]);
                check((d == 0) ? "reqin" : "reqin8", g_in, e_in[d]);
                check((d == 0) ? "sense" : "sense8", g_sense, m_sense[d]);
            end
        end
        if (!rstn) begin
            for (int d = 0; d < 2; d++) begin
                m_gen[d] = 0; m_mask[d] = '0; m_sense[d] = '0; e_wr[d] = '0; e_in[d] = '0;
            end
            p_valid = 0; p_write = 0; p_size_ok = 0; p_off = '0;
            m_init = 1;
        end else if (m_init) begin
            for (int d = 0; d < 2; d++) begin
                e_wr[d] = '0; e_in[d] = '0;
                if (p_valid && p_write && p_size_ok) model_write(d, p_off, wdata);
            end
            p_valid = sel && hready && trans[1];
            if (p_valid) begin
                p_write = wr; p_off = boff[5:2]; p_size_ok = (size == 3'b010);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic addr_wr(input logic [5:0] a, input logic [31:0] prev);
        cyc(1'b1, 2'b10, 1'b1, a, 3'b010, prev);
    endtask

    task automatic addr_rd(input logic [5:0] a, input logic [31:0] prev);
        cyc(1'b1, 2'b10, 1'b0, a, 3'b010, prev);
    endtask

    task automatic idle(input logic [31:0] prev);
        cyc(1'b0, 2'b00, 1'b0, 6'h00, 3'b010, prev);
    endtask

    initial begin
        rstn = 0; hready = 1; req = '0; irq = '0;
        hsel = 0; htrans = 2'b00; hwrite = 0; haddr = '0; hsize = 3'b010; hwdata = '0;
        @(posedge CLK); #1;
        idle(0); idle(0);
        check("rst_mask_out", s_mask, 64'd0);
        check("rst_reqwr", s_wr, 64'd0);
        rstn = 1;

        addr_rd(6'h00, 0);
        addr_rd(6'h04, 0);  check("rst_ctrl", 64'(s_hrdata), 64'd0);
        addr_rd(6'h24, 0);  check("rst_mask0", 64'(s_hrdata), 64'd0);
        idle(0);            check("rst_sense0", 64'(s_hrdata), 64'd0);

        addr_wr(6'h00, 0);
        addr_wr(6'h04, 32'd1);
        addr_rd(6'h04, 32'h0000_00F0);
        idle(0);
        check("raw_mask0", 64'(s_hrdata), 64'hF0);
        check("mask_out_f0", s_mask, 64'hF0);
        addr_wr(6'h00, 0);
        addr_rd(6'h04, 32'd0);
        idle(0);
        check("mask0_kept", 64'(s_hrdata), 64'hF0);
        check("gen_off_mask", s_mask, 64'd0);

        addr_wr(6'h18, 0);
        addr_wr(6'h20, 32'h5);
        idle(32'h1);
        check("fset1_wr", s_wr, 64'h5_0000_0000);
        check("fset1_in", s_in, 64'h5_0000_0000);
        idle(0);
        check("fclr1_wr", s_wr, 64'h1_0000_0000);
        check("fclr1_in", s_in, 64'd0);
        idle(0);
        check("strobe_end", s_wr, 64'd0);

        addr_wr(6'h14, 0); idle(32'h8000_0001); idle(0);
        check("fset0_wr", s_wr, 64'h8000_0001);
        addr_wr(6'h1C, 0); idle(32'h0); idle(0);
        check("fclr_zero", s_wr, 64'd0);

        cyc(1'b1, 2'b10, 1'b1, 6'h24, 3'b000, 0);
        addr_rd(6'h24, 32'hFFFF_FFFF);
        idle(0);
        check("sense_byte", 64'(s_hrdata), 64'd0);
        addr_wr(6'h24, 0);
        addr_rd(6'h24, 32'hFFFF_FFFF);
        idle(0);
        check("sense_word", 64'(s_hrdata), 64'hFFFF_FFFF);
        check("sense_out", s_sense & 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        check("sense8_rd", 64'(s_hrdata8), 64'h0000_FFFF);
        addr_wr(6'h28, 0);
        addr_rd(6'h28, 32'hFFFF_FFFF);
        idle(0);
        check("sense1_rd", 64'(s_hrdata), 64'hFFFF_FFFF);
        check("sense1_8_rd", 64'(s_hrdata8), 64'd0);
        addr_wr(6'h08, 0);
        addr_rd(6'h08, 32'hFFFF_FFFF);
        idle(0);
        check("mask1_8_rd", 64'(s_hrdata8), 64'hFF);

        req = 64'h1_0000_0002; irq = 8'h02;
        addr_rd(6'h0C, 0);
        addr_rd(6'h10, 0);  check("flag0", 64'(s_hrdata), 64'h2);
        addr_rd(6'h2C, 0);  check("flag1", 64'(s_hrdata), 64'h1);
        addr_rd(6'h3C, 0);  check("irq", 64'(s_hrdata), 64'h2);
        idle(0);            check("unmapped", 64'(s_hrdata), 64'd0);

        addr_wr(6'h04, 0);
        rstn = 0; idle(32'hFFFF_FFFF); rstn = 1;
        addr_rd(6'h04, 0);
        idle(0);
        check("rst_mid_mask0", 64'(s_hrdata), 64'd0);
        addr_wr(6'h14, 0);
        rstn = 0; idle(32'hFFFF_FFFF); rstn = 1;
        idle(0);
        check("rst_mid_strobe", s_wr, 64'd0);
        cyc(1'b1, 2'b00, 1'b1, 6'h14, 3'b010, 0); idle(32'hFFFF_FFFF); idle(0);
        check("idle_nostrobe", s_wr, 64'd0);
        cyc(1'b1, 2'b01, 1'b1, 6'h14, 3'b010, 0); idle(32'hFFFF_FFFF); idle(0);
        check("busy_nostrobe", s_wr, 64'd0);
        cyc(1'b0, 2'b10, 1'b1, 6'h14, 3'b010, 0); idle(32'hFFFF_FFFF); idle(0);
        check("nosel_nostrobe", s_wr, 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] sz;
            rstn   = ($urandom_range(0, 99) != 0);
            req    = {$urandom(), $urandom()};
            irq    = 8'($urandom());
            hready = p_valid ? 1'b1 : ($urandom_range(0, 7) != 0);
            sz     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            cyc(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                {4'($urandom_range(0, 15)), 2'b00}, sz,
                ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom());
        end
        hready = 1; rstn = 1;
        idle(0); idle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
